// File: rtl/ai_move_engine_if.sv
// ai_move_engine_if: turn request, board snapshot source and move offer handshake between controller, board and AI engine
interface ai_move_engine_if;
    logic        start;
    logic [17:0] board;
    logic [1:0]  win;
    logic        move_ack;
    logic        busy;
    logic        move_valid;
    logic [1:0]  move_row;
    logic [1:0]  move_col;
    logic [1:0]  move_xoro;
    logic        no_move;
    modport master (
        output start, board, win, move_ack,
        input  busy, move_valid, move_row, move_col, move_xoro, no_move
    );
    modport slave (
        input  start, board, win, move_ack,
        output busy, move_valid, move_row, move_col, move_xoro, no_move
    );
endinterface

// File: rtl/ai_move_engine.sv
// ai_move_engine: snapshots the board on start, scans one priority step per cycle, offers a single AI placement
module ai_move_engine #(
    parameter logic [1:0] AI_MARK    = 2'b10,
    parameter logic [1:0] HUMAN_MARK = 2'b01,
    parameter bit         EN_BLOCK   = 1'b1
) (
    input logic             clk,
    input logic             reset,
    ai_move_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, OFFER, NOMOVE} state_t;
    state_t      state, state_nx;
    logic [4:0]  step, step_nx;
    logic [17:0] snap, snap_nx;
    logic [1:0]  row, col, row_nx, col_nx;
    logic [11:0] lc;
    logic [1:0]  mark, v0, v1, v2, hits, empties;
    logic [3:0]  sc, target;
    logic        line_hit, hit;

    function automatic logic [11:0] line_cells(input logic [2:0] k);
        case (k)
            3'd0:    return {4'd0, 4'd1, 4'd2};
            3'd1:    return {4'd3, 4'd4, 4'd5};
            3'd2:    return {4'd6, 4'd7, 4'd8};
            3'd3:    return {4'd0, 4'd3, 4'd6};
            3'd4:    return {4'd1, 4'd4, 4'd7};
            3'd5:    return {4'd2, 4'd5, 4'd8};
            3'd6:    return {4'd0, 4'd4, 4'd8};
            default: return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    function automatic logic [3:0] single_cell(input logic [4:0] s);
        case (s)
            5'd16:   return 4'd4;
            5'd17:   return 4'd0;
            5'd18:   return 4'd2;
            5'd19:   return 4'd6;
            5'd20:   return 4'd8;
            5'd21:   return 4'd1;
            5'd22:   return 4'd3;
            5'd23:   return 4'd5;
            default: return 4'd7;
        endcase
    endfunction

    function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] i);
        return b[{i, 1'b0} +: 2];
    endfunction

    // evaluate the current scan step against the snapshot; code 11 never equals a mark nor reads as empty
    always_comb begin
        lc       = line_cells(step[2:0]);
        mark     = step[3] ? HUMAN_MARK : AI_MARK;
        v0       = cell_of(snap, lc[11:8]);
        v1       = cell_of(snap, lc[7:4]);
        v2       = cell_of(snap, lc[3:0]);
        hits     = 2'(v0 == mark) + 2'(v1 == mark) + 2'(v2 == mark);
        empties  = 2'(v0 == 2'b00) + 2'(v1 == 2'b00) + 2'(v2 == 2'b00);
        line_hit = hits == 2'd2 && empties == 2'd1 && (!step[3] || EN_BLOCK);
        sc       = single_cell(step);
        hit      = step[4] ? cell_of(snap, sc) == 2'b00 : line_hit;
        target   = step[4] ? sc : v0 == 2'b00 ? lc[11:8] : v1 == 2'b00 ? lc[7:4] : lc[3:0];
    end

    // next-state, snapshot capture and move coordinate selection
    always_comb begin
        state_nx = state;
        step_nx  = step;
        snap_nx  = snap;
        row_nx   = row;
        col_nx   = col;
        case (state)
            IDLE: if (bus.start) begin
                if (bus.win != 2'b00) state_nx = NOMOVE;
                else begin
                    snap_nx  = bus.board;
                    step_nx  = 5'd0;
                    state_nx = SCAN;
                end
            end
            SCAN: if (hit) begin
                row_nx   = target >= 4'd6 ? 2'd2 : target >= 4'd3 ? 2'd1 : 2'd0;
                col_nx   = (target == 4'd1 || target == 4'd4 || target == 4'd7) ? 2'd1 :
                           (target == 4'd2 || target == 4'd5 || target == 4'd8) ? 2'd2 : 2'd0;
                state_nx = OFFER;
            end else if (step == 5'd24) state_nx = NOMOVE;
            else step_nx = step + 5'd1;
            OFFER:   if (bus.move_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, step counter, snapshot and offered coordinates
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            step  <= 5'd0;
            snap  <= 18'd0;
            row   <= 2'd0;
            col   <= 2'd0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            snap  <= snap_nx;
            row   <= row_nx;
            col   <= col_nx;
        end
    end

    assign bus.busy       = state != IDLE;
    assign bus.move_valid = state == OFFER;
    assign bus.move_row   = state == OFFER ? row : 2'd0;
    assign bus.move_col   = state == OFFER ? col : 2'd0;
    assign bus.move_xoro  = state == OFFER ? AI_MARK : 2'd0;
    assign bus.no_move    = state == NOMOVE;
endmodule

// File: tb/tb_ai_move_engine.sv
// tb_ai_move_engine: directed scan-priority, latency, handshake and reset checks for ai_move_engine
module tb_ai_move_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;

    ai_move_engine_if bus ();
    ai_move_engine_if bus2 ();

    ai_move_engine dut (.clk(clk), .reset(reset), .bus(bus.slave));
    ai_move_engine #(.EN_BLOCK(1'b0)) dut_nb (.clk(clk), .reset(reset), .bus(bus2.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [17:0] bd(input logic [8:0] x, input logic [8:0] o, input logic [8:0] inv);
        logic [17:0] b = '0;
        for (int i = 0; i < 9; i++) begin
            if (x[i]) b[2*i +: 2] = 2'b01;
            if (o[i]) b[2*i +: 2] = 2'b10;
            if (inv[i]) b[2*i +: 2] = 2'b11;
        end
        return b;
    endfunction

    task automatic start_move(input logic [17:0] b, input logic [1:0] w);
        bus.board = b;
        bus.win = w;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int lat, input logic [1:0] r, input logic [1:0] c);
        int n = 1;
        while (!bus.move_valid && n < 40) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_rc"}, {bus.move_row, bus.move_col, bus.move_xoro}, {r, c, 2'b10});
    endtask

    task automatic wait_nomove(input string tag, input int lat);
        int   n = 1;
        logic seen = 1'b0;
        while (!bus.no_move && n < 40) begin
            seen |= bus.move_valid;
            tick;
            n++;
        end
        seen |= bus.move_valid;
        check({tag, "_lat"}, n, lat);
        check({tag, "_novalid"}, seen, 1'b0);
        tick;
        check({tag, "_pulse"}, {bus.no_move, bus.busy}, 2'b00);
    endtask

    task automatic ack_now(input string tag);
        bus.move_ack = 1'b1;
        tick;
        bus.move_ack = 1'b0;
        check({tag, "_ackdone"}, {bus.busy, bus.move_valid}, 2'b00);
    endtask

    initial begin
        logic seen;
        int   n;
        bus.start = 1'b0;
        bus.board = '0;
        bus.win = 2'b00;
        bus.move_ack = 1'b0;
        bus2.start = 1'b0;
        bus2.board = '0;
        bus2.win = 2'b00;
        bus2.move_ack = 1'b0;
        tick;
        tick;
        check("reset_outs", {bus.busy, bus.move_valid, bus.move_row, bus.move_col, bus.move_xoro, bus.no_move}, 9'd0);
        reset = 1'b0;
        tick;

        start_move(18'd0, 2'b00);
        check("empty_busy", bus.busy, 1'b1);
        wait_valid("empty_center", 18, 2'd1, 2'd1);
        tick;
        check("empty_hold", bus.move_valid, 1'b1);
        bus.move_ack = 1'b1;
        tick;
        bus.move_ack = 1'b0;
        check("empty_busy_low", {bus.busy, bus.move_valid}, 2'b00);

        start_move(bd(9'b100011000, 9'b000000011, 9'd0), 2'b00);
        wait_valid("win_first", 2, 2'd0, 2'd2);
        ack_now("win_first");

        start_move(bd(9'b000010001, 9'b000000010, 9'd0), 2'b00);
        wait_valid("block_diag", 16, 2'd2, 2'd2);
        ack_now("block_diag");

        bus2.board = bd(9'b000010001, 9'b000000010, 9'd0);
        bus2.start = 1'b1;
        tick;
        bus2.start = 1'b0;
        n = 1;
        while (!bus2.move_valid && n < 40) begin
            tick;
            n++;
        end
        check("noblock_lat", n, 20);
        check("noblock_rc", {bus2.move_row, bus2.move_col, bus2.move_xoro}, {2'd0, 2'd2, 2'b10});
        bus2.move_ack = 1'b1;
        tick;
        bus2.move_ack = 1'b0;
        check("noblock_done", bus2.busy, 1'b0);

        start_move(bd(9'b101100011, 9'b010011100, 9'd0), 2'b00);
        wait_nomove("full_board", 26);

        start_move(18'd0, 2'b01);
        wait_nomove("game_over", 1);

        start_move(bd(9'd0, 9'd0, 9'b000010000), 2'b00);
        wait_valid("inv_center", 19, 2'd0, 2'd0);
        ack_now("inv_center");

        start_move(18'd0, 2'b00);
        bus.board = bd(9'd0, 9'b000000011, 9'd0);
        tick;
        tick;
        tick;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        n = 5;
        while (!bus.move_valid && n < 40) begin
            tick;
            n++;
        end
        check("snap_lat", n, 18);
        check("snap_rc", {bus.move_row, bus.move_col}, {2'd1, 2'd1});
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            seen |= ({bus.move_valid, bus.move_row, bus.move_col, bus.move_xoro} !== {1'b1, 2'd1, 2'd1, 2'b10});
        end
        check("offer_stable", seen, 1'b0);
        bus.move_ack = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.move_ack = 1'b0;
        bus.start = 1'b0;
        check("exit_start_ignored", {bus.busy, bus.move_valid}, 2'b00);
        tick;
        check("exit_start_idle", bus.busy, 1'b0);

        bus.move_ack = 1'b1;
        tick;
        bus.move_ack = 1'b0;
        check("ack_idle_ignored", {bus.busy, bus.move_valid, bus.no_move}, 3'b000);

        start_move(18'd0, 2'b00);
        for (int i = 0; i < 10; i++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midscan_reset", {bus.busy, bus.move_valid, bus.move_row, bus.move_col, bus.move_xoro, bus.no_move}, 9'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            seen |= bus.move_valid | bus.busy | bus.no_move;
        end
        check("midscan_abort", seen, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
